// File: rtl/axi4_rd_arbiter_pkg.sv
// rtl/axi4_rd_arbiter_pkg.sv - shared FSM encodings, response codes and default widths
package axi4_rd_arbiter_pkg;

    localparam int DEF_NUM_M  = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4_rd_arbiter_rr.sv
// rtl/axi4_rd_arbiter_rr.sv - combinational round-robin pick, search starts just after last owner
module axi4_rd_arbiter_rr
    import axi4_rd_arbiter_pkg::*;
#(
    parameter  int NUM_M = DEF_NUM_M,
    localparam int GW    = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [GW-1:0]    last,
    output logic [GW-1:0]    winner,
    output logic             any
);

    logic [GW-1:0] idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        // Offsets 1..NUM_M visit every master once, ending on last itself.
        for (int i = 1; i <= NUM_M; i++) begin
            idx = GW'((int'(last) + i) % NUM_M);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/axi4_rd_arbiter.sv
// rtl/axi4_rd_arbiter.sv - round-robin share of one single-beat AXI4 read port among NUM_M masters
module axi4_rd_arbiter
    import axi4_rd_arbiter_pkg::*;
#(
    parameter  int NUM_M  = DEF_NUM_M,
    parameter  int ADDR_W = DEF_ADDR_W,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int GW     = $clog2(NUM_M)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_M*ADDR_W-1:0] m_araddr,
    input  logic [NUM_M-1:0]        m_arvalid,
    output logic [NUM_M-1:0]        m_arready,
    output logic [DATA_W-1:0]       m_rdata,
    output logic [1:0]              m_rresp,
    output logic [NUM_M-1:0]        m_rvalid,
    input  logic [NUM_M-1:0]        m_rready,
    output logic [ADDR_W-1:0]       s_araddr,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    input  logic [DATA_W-1:0]       s_rdata,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    output logic [GW-1:0]           grant,
    output logic                    busy
);

    state_e        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [GW-1:0] rr_winner;
    logic          rr_any;
    logic          sel_arvalid;
    logic          sel_rready;
    logic [ADDR_W-1:0] sel_araddr;

    axi4_rd_arbiter_rr #(.NUM_M(NUM_M)) u_rr (
        .req    (m_arvalid),
        .last   (last_q),
        .winner (rr_winner),
        .any    (rr_any)
    );

    always_comb begin
        sel_arvalid = 1'b0;
        sel_rready  = 1'b0;
        sel_araddr  = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q == GW'(i)) begin
                sel_arvalid = m_arvalid[i];
                sel_rready  = m_rready[i];
                sel_araddr  = m_araddr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (rr_any) begin
                    grant_d = rr_winner;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // A master withdrawing its request aborts without advancing the rotation.
                if (!sel_arvalid) begin
                    state_d = ST_IDLE;
                end else if (s_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (s_rvalid && sel_rready) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        s_araddr  = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        m_rdata   = s_rdata;
        m_rresp   = s_rresp;
        busy      = (state_q != ST_IDLE);
        if (state_q == ST_ADDR) begin
            s_araddr  = sel_araddr;
            s_arvalid = sel_arvalid;
        end
        if (state_q == ST_DATA) begin
            s_rready = sel_rready;
        end
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q == GW'(i)) begin
                m_arready[i] = (state_q == ST_ADDR) && s_arready;
                m_rvalid[i]  = (state_q == ST_DATA) && s_rvalid;
            end
        end
    end

    assign grant = grant_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// tb/tb_axi4_rd_arbiter.sv - directed self-checking bench for axi4_rd_arbiter
module tb_axi4_rd_arbiter;
    import axi4_rd_arbiter_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic [127:0]  m_araddr;
    logic [3:0]    m_arvalid;
    logic [3:0]    m_arready;
    logic [31:0]   m_rdata;
    logic [1:0]    m_rresp;
    logic [3:0]    m_rvalid;
    logic [3:0]    m_rready;
    logic [31:0]   s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic [1:0]    grant;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int r_hs  = 0;

    axi4_rd_arbiter #(.NUM_M(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && s_rvalid && s_rready) r_hs <= r_hs + 1;
    end

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [1:0]  exp_grant;
        logic [3:0]  exp_onehot;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_read(input vec_t v);
        m_arvalid = '0;
        m_arvalid[v.m] = 1'b1;
        m_araddr[v.m*32 +: 32] = v.addr;
        m_rready  = v.exp_onehot;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_arvalid", s_arvalid, 0);
        tick();
        chk("addr_grant", grant, v.exp_grant);
        chk("addr_s_arvalid", s_arvalid, 1);
        chk("addr_s_araddr", s_araddr, v.addr);
        chk("addr_arready_held", m_arready, 0);
        s_arready = 1'b1;
        #1;
        chk("addr_arready", m_arready, v.exp_onehot);
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = v.data;
        s_rresp   = v.resp;
        #1;
        chk("data_m_rvalid", m_rvalid, v.exp_onehot);
        chk("data_m_rdata", m_rdata, v.data);
        chk("data_m_rresp", m_rresp, v.resp);
        chk("data_s_rready", s_rready, 1);
        chk("data_s_arvalid", s_arvalid, 0);
        tick();
        s_rvalid = 1'b0;
        m_rready = '0;
        #1;
        chk("done_busy", busy, 0);
        chk("done_m_rvalid", m_rvalid, 0);
    endtask

    // Zero-wait slave assumed: s_arready, s_rvalid and all m_rready held high.
    task automatic slot(input int k, input bit drop);
        logic [3:0] oh;
        oh = 4'b0001 << k;
        tick();
        chk("rr_grant", grant, k);
        chk("rr_arready", m_arready, oh);
        tick();
        if (drop) m_arvalid[k] = 1'b0;
        chk("rr_rvalid", m_rvalid, oh);
        tick();
        chk("rr_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{m: 2, addr: 32'h0000_1000, data: 32'h1234_5678, resp: RESP_OKAY,   exp_grant: 2'd2, exp_onehot: 4'b0100};
        vecs[1] = '{m: 1, addr: 32'h0000_2004, data: 32'hdead_beef, resp: RESP_SLVERR, exp_grant: 2'd1, exp_onehot: 4'b0010};
        vecs[2] = '{m: 3, addr: 32'hffff_fffc, data: 32'h0000_0000, resp: RESP_DECERR, exp_grant: 2'd3, exp_onehot: 4'b1000};
        vecs[3] = '{m: 0, addr: 32'h0000_0010, data: 32'ha5a5_a5a5, resp: RESP_EXOKAY, exp_grant: 2'd0, exp_onehot: 4'b0001};

        reset = 1'b0;
        m_araddr = '0; m_arvalid = '0; m_rready = '0;
        s_arready = 1'b0; s_rdata = 32'h5555_aaaa; s_rresp = 2'b01; s_rvalid = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_arready", m_arready, 0);
        chk("rst_rvalid", m_rvalid, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_s_araddr", s_araddr, 0);
        chk("rst_rdata_pass", m_rdata, 32'h5555_aaaa);
        chk("rst_rresp_pass", m_rresp, 2'b01);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) do_read(vecs[i]);

        // Simultaneous requests after a fresh reset: grants 0,1,2,3.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) m_araddr[i*32 +: 32] = 32'h100 * (i + 1);
        s_arready = 1'b1; s_rvalid = 1'b1; m_rready = 4'b1111;
        m_arvalid = 4'b1111;
        #1;
        chk("sim_idle_busy", busy, 0);
        for (int k = 0; k < 4; k++) slot(k, 1'b1);

        // Fairness: 0 and 3 request continuously.
        m_arvalid = 4'b1001;
        slot(0, 1'b0);
        slot(3, 1'b0);
        slot(0, 1'b0);
        slot(3, 1'b0);
        m_arvalid = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; m_rready = '0;
        tick();

        // Backpressure on AR then on R for master 1.
        begin
            int hs0;
            hs0 = r_hs;
            m_araddr[32 +: 32] = 32'h0000_4000;
            m_arvalid = 4'b0010;
            tick();
            for (int c = 0; c < 5; c++) begin
                chk("bp_ar_valid", s_arvalid, 1);
                chk("bp_ar_addr", s_araddr, 32'h0000_4000);
                chk("bp_ar_grant", grant, 1);
                chk("bp_ar_ready", m_arready, 0);
                tick();
            end
            s_arready = 1'b1;
            #1;
            chk("bp_ar_hs", m_arready, 4'b0010);
            tick();
            m_arvalid = '0;
            s_arready = 1'b0;
            s_rvalid  = 1'b1;
            s_rdata   = 32'hcafe_f00d;
            s_rresp   = RESP_OKAY;
            for (int c = 0; c < 3; c++) begin
                #1;
                chk("bp_r_rvalid", m_rvalid, 4'b0010);
                chk("bp_r_grant", grant, 1);
                chk("bp_r_s_rready", s_rready, 0);
                tick();
            end
            m_rready = 4'b0010;
            tick();
            s_rvalid = 1'b0;
            m_rready = '0;
            tick();
            chk("bp_one_hs", r_hs - hs0, 1);
            chk("bp_idle", busy, 0);
        end

        // Reset asserted in DATA abandons the transaction.
        m_araddr[2*32 +: 32] = 32'h0000_8000;
        m_araddr[0 +: 32]    = 32'h0000_0abc;
        m_arvalid = 4'b0100;
        s_arready = 1'b1;
        tick();
        tick();
        m_arvalid = '0;
        s_arready = 1'b0;
        #1;
        chk("rstd_in_data", busy, 1);
        reset = 1'b0;
        tick();
        chk("rstd_busy", busy, 0);
        chk("rstd_grant", grant, 0);
        chk("rstd_arready", m_arready, 0);
        chk("rstd_rvalid", m_rvalid, 0);
        chk("rstd_s_arvalid", s_arvalid, 0);
        chk("rstd_s_rready", s_rready, 0);
        reset = 1'b1;
        m_arvalid = 4'b1001;
        tick();
        chk("rstd_win0", grant, 0);
        chk("rstd_addr0", s_araddr, 32'h0000_0abc);
        chk("rstd_s_arvalid_on", s_arvalid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
